truth_table_sweeper: RTL

Sequencer that exhaustively drives the 3-input truth-table combinational block: it steps {a,b,c} through all 8 vectors, waits a settle time per vector, and captures output X into an 8-bit result word. It compares the captured word against a latched expected pattern and reports the mismatch count and a pass flag. It sits between a test/control source (start, expected) and the combinational block under test.

---
 rtl/truth_table_sweeper.sv | 91 +++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive 3-input truth-table sweeper: walks {a,b,c} through all 8 vectors,
// samples x_in after a settle time and scores the captured word against a latched pattern.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       x_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [3:0] mismatch_cnt,
  output logic       match
);

  localparam logic [0:0]       IDLE   = 1'b0;
  localparam logic [0:0]       SWEEP  = 1'b1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [0:0]       state;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       exp_lat;
  logic [7:0]       result_next;
  logic             miss;

  // Result word including the bit captured on this edge, so the final compare sees vector 7.
  always_comb begin
    result_next      = result;
    result_next[idx] = x_in;
  end

  assign miss = (x_in != exp_lat[idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 3'd0;
      cnt          <= '0;
      exp_lat      <= 8'h00;
      result       <= 8'h00;
      mismatch_cnt <= 4'd0;
      match        <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= SWEEP;
            idx          <= 3'd0;
            cnt          <= RELOAD;
            exp_lat      <= expected;
            result       <= 8'h00;
            mismatch_cnt <= 4'd0;
            match        <= 1'b0;
          end
        end
        SWEEP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            result <= result_next;
            if (miss) mismatch_cnt <= mismatch_cnt + 4'd1;
            if (idx != 3'd7) begin
              idx <= idx + 3'd1;
              cnt <= RELOAD;
            end else begin
              // Returning idx to 0 also parks a,b,c low while idle.
              state <= IDLE;
              idx   <= 3'd0;
              done  <= 1'b1;
              match <= (result_next == exp_lat);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == SWEEP);
  assign {a, b, c} = idx;

endmodule
